nn_layer_sequencer: RTL

// Top-level scheduler for the two-layer NN coprocessor. On each received input frame it

---
 rtl/nn_layer_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: per-frame scheduler for the two-layer NN coprocessor.
// Runs hidden layer -> predictor -> output streamer through start/done
// handshakes. It also owns the hRES RAM port select, runs a per-stage
// watchdog, and keeps sticky error / overrun flags plus a completed-frame
// counter.
module nn_layer_sequencer #(
  parameter int TIMEOUT_BITS   = 16,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FRAME_CNT_BITS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_done,
  output logic                      hid_start,
  input  logic                      hid_done,
  output logic                      pred_start,
  input  logic                      pred_done,
  output logic                      tx_start,
  input  logic                      tx_done,
  output logic                      hres_sel,
  output logic                      busy,
  output logic                      err,
  output logic [1:0]                err_stage,
  output logic                      overrun,
  input  logic                      clear_err,
  output logic [FRAME_CNT_BITS-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HID_START  = 3'd1,
    HID_WAIT   = 3'd2,
    PRED_START = 3'd3,
    PRED_WAIT  = 3'd4,
    TX_START   = 3'd5,
    TX_WAIT    = 3'd6,
    ERROR      = 3'd7
  } state_t;

  localparam logic [1:0] STAGE_NONE = 2'd0;
  localparam logic [1:0] STAGE_HID  = 2'd1;
  localparam logic [1:0] STAGE_PRED = 2'd2;
  localparam logic [1:0] STAGE_TX   = 2'd3;

  // Last count value of a WAIT state before the watchdog fires.
  localparam logic [TIMEOUT_BITS-1:0] WD_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

  state_t                    state_q, state_d;
  logic [TIMEOUT_BITS-1:0]   wd_q, wd_d;
  logic                      err_q, err_d;
  logic [1:0]                err_stage_q, err_stage_d;
  logic                      overrun_q, overrun_d;
  logic [FRAME_CNT_BITS-1:0] frame_cnt_q, frame_cnt_d;

  logic       in_wait;
  logic       wd_expired;
  logic       err_set;
  logic [1:0] err_stage_set;
  logic       overrun_set;
  logic       frame_inc;

  assign in_wait    = (state_q == HID_WAIT) || (state_q == PRED_WAIT) || (state_q == TX_WAIT);
  // A zero timeout disables the watchdog entirely.
  assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);
  // Frames arriving while a sequence is running (or while in ERROR) are dropped.
  assign overrun_set = rx_done && (state_q != IDLE);

  // Next-state decode; done inputs only count in their own WAIT state, and done beats expiry.
  always_comb begin
    state_d       = state_q;
    err_set       = 1'b0;
    err_stage_set = STAGE_NONE;
    frame_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_done) begin
          state_d = HID_START;
        end else begin
          state_d = IDLE;
        end
      end
      HID_START: state_d = HID_WAIT;
      HID_WAIT: begin
        if (hid_done) begin
          state_d = PRED_START;
        end else if (wd_expired) begin
          state_d       = ERROR;
          err_set       = 1'b1;
          err_stage_set = STAGE_HID;
        end else begin
          state_d = HID_WAIT;
        end
      end
      PRED_START: state_d = PRED_WAIT;
      PRED_WAIT: begin
        if (pred_done) begin
          state_d = TX_START;
        end else if (wd_expired) begin
          state_d       = ERROR;
          err_set       = 1'b1;
          err_stage_set = STAGE_PRED;
        end else begin
          state_d = PRED_WAIT;
        end
      end
      TX_START: state_d = TX_WAIT;
      TX_WAIT: begin
        if (tx_done) begin
          state_d   = IDLE;
          frame_inc = 1'b1;
        end else if (wd_expired) begin
          state_d       = ERROR;
          err_set       = 1'b1;
          err_stage_set = STAGE_TX;
        end else begin
          state_d = TX_WAIT;
        end
      end
      ERROR: begin
        if (clear_err) begin
          state_d = IDLE;
        end else begin
          state_d = ERROR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog counts cycles spent in a WAIT state; any other state zeroes it so each WAIT starts at 0.
  always_comb begin
    wd_d = '0;
    if (in_wait) begin
      wd_d = wd_q + {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};
    end else begin
      wd_d = '0;
    end
  end

  // Sticky flags: clear_err clears them, but a set in the same cycle takes priority.
  always_comb begin
    err_d       = err_q;
    err_stage_d = err_stage_q;
    overrun_d   = overrun_q;
    if (clear_err) begin
      err_d       = 1'b0;
      err_stage_d = STAGE_NONE;
      overrun_d   = 1'b0;
    end else begin
      err_d       = err_q;
      err_stage_d = err_stage_q;
      overrun_d   = overrun_q;
    end
    if (err_set) begin
      err_d       = 1'b1;
      err_stage_d = err_stage_set;
    end else begin
      err_d       = err_d;
      err_stage_d = err_stage_d;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_d;
    end
  end

  // Completed-frame counter, wrapping naturally at its width.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_inc) begin
      frame_cnt_d = frame_cnt_q + {{(FRAME_CNT_BITS-1){1'b0}}, 1'b1};
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      err_q       <= 1'b0;
      err_stage_q <= STAGE_NONE;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      err_stage_q <= err_stage_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // All outputs come straight from registers; no input reaches an output combinationally.
  assign hid_start  = (state_q == HID_START);
  assign pred_start = (state_q == PRED_START);
  assign tx_start   = (state_q == TX_START);
  assign hres_sel   = (state_q == PRED_START) || (state_q == PRED_WAIT);
  assign busy       = (state_q != IDLE) && (state_q != ERROR);
  assign err        = err_q;
  assign err_stage  = err_stage_q;
  assign overrun    = overrun_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
